// File: rtl/muldiv_ctl_pkg.sv
// ============================================================================
// muldiv_ctl_pkg : shared mul/div bus types, op encoding and controller states
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_ctl_pkg;

    typedef logic [63:0] u64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef struct packed {
        op_e  op;
        logic dw;
        u64   ia;
        u64   ib;
        u64   ia_orig;
    } mbus_req_t;

    typedef logic [2:0] muldiv_ctl_state_t;

    localparam muldiv_ctl_state_t ST_IDLE   = 3'd0;
    localparam muldiv_ctl_state_t ST_LAUNCH = 3'd1;
    localparam muldiv_ctl_state_t ST_WAIT   = 3'd2;
    localparam muldiv_ctl_state_t ST_RESP   = 3'd3;
    localparam muldiv_ctl_state_t ST_FLUSH  = 3'd4;

    function automatic logic is_mul_op(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    // dw=0 ops only look at the low word; upper bits are don't-care there.
    function automatic logic has_zero_operand(input mbus_req_t r);
        if (r.dw)
            return (r.ia == '0) || (r.ib == '0);
        return (r.ia[31:0] == '0) || (r.ib[31:0] == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_ctl_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin one-hot grant, search starts one past ptr_i
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    logic [IDW-1:0] pos;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        pos   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            pos = IDW'((int'(ptr_i) + k) % N);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
        any_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctl.sv
// ============================================================================
// muldiv_ctl : round-robin front end for the multicycle mul/div core
// Optional zero-operand MUL bypass: MULDIV_FASTPATH_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_ctl
    import muldiv_ctl_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [NREQ-1:0] req_valid_i,
    output logic [NREQ-1:0] req_ready_o,
    input  mbus_req_t       req_i [NREQ],
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [IDW-1:0]  resp_id_o,
    output u64              resp_data_o,
    output logic            resp_divzero_o,
    output logic            core_rst_o,
    output logic            core_op_begin_o,
    output mbus_req_t       core_req_o,
    input  logic            core_busy_i,
    input  u64              core_out_i,
    input  logic            core_divzero_i
);

    muldiv_ctl_state_t state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    mbus_req_t         req_q, req_d;
    logic              resp_valid_q, resp_valid_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    u64                resp_data_q, resp_data_d;
    logic              resp_divzero_q, resp_divzero_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    win_idx;
    logic              win_any;
    logic              fast;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

`ifdef MULDIV_FASTPATH_EN
    assign fast = is_mul_op(req_i[win_idx].op) && has_zero_operand(req_i[win_idx]);
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        id_d           = id_q;
        req_d          = req_q;
        resp_valid_d   = resp_valid_q;
        resp_id_d      = resp_id_q;
        resp_data_d    = resp_data_q;
        resp_divzero_d = resp_divzero_q;

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    req_d = req_i[win_idx];
                    id_d  = win_idx;
                    ptr_d = win_idx;
                    if (fast) begin
                        resp_data_d    = '0;
                        resp_divzero_d = 1'b0;
                        resp_id_d      = win_idx;
                        resp_valid_d   = 1'b1;
                        state_d        = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            // The core's ready level is sticky, so only busy falling marks completion.
            ST_WAIT: begin
                if (!core_busy_i) begin
                    resp_data_d    = core_out_i;
                    resp_divzero_d = core_divzero_i;
                    resp_id_d      = id_q;
                    resp_valid_d   = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (flush_i && (state_q != ST_IDLE)) begin
            state_d      = ST_FLUSH;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            id_q           <= '0;
            req_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_data_q    <= '0;
            resp_divzero_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            id_q           <= id_d;
            req_q          <= req_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_data_q    <= resp_data_d;
            resp_divzero_q <= resp_divzero_d;
        end
    end

    assign req_ready_o     = (state_q == ST_IDLE) ? gnt : '0;
    assign resp_valid_o    = resp_valid_q;
    assign resp_id_o       = resp_id_q;
    assign resp_data_o     = resp_data_q;
    assign resp_divzero_o  = resp_divzero_q;
    assign core_rst_o      = !rst_n || (state_q == ST_FLUSH);
    assign core_op_begin_o = (state_q == ST_LAUNCH);
    assign core_req_o      = req_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctl.sv
// tb_muldiv_ctl : directed + random bench for muldiv_ctl with a behavioural mul/div core.
// Expected results come from plain arithmetic on the issued ops and a round-robin pointer model.
`default_nettype none

module tb_muldiv_ctl;
    import muldiv_ctl_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = $clog2(NREQ);

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    mbus_req_t       req [NREQ];
    logic            resp_valid;
    logic            resp_ready;
    logic [IDW-1:0]  resp_id;
    u64              resp_data;
    logic            resp_divzero;
    logic            core_rst;
    logic            core_op_begin;
    mbus_req_t       core_req;
    logic            core_busy;
    u64              core_out;
    logic            core_divzero;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;
    int core_lat = 0;
    int nbegin = 0;
    int cnt = 0;
    u64   res_q = '0;
    logic dz_q  = 1'b0;

    muldiv_ctl #(.NREQ(NREQ)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_i           (req),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_id_o       (resp_id),
        .resp_data_o     (resp_data),
        .resp_divzero_o  (resp_divzero),
        .core_rst_o      (core_rst),
        .core_op_begin_o (core_op_begin),
        .core_req_o      (core_req),
        .core_busy_i     (core_busy),
        .core_out_i      (core_out),
        .core_divzero_i  (core_divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic u64 ref_data(input mbus_req_t r);
        logic signed [63:0] sa, sb;
        sa = r.ia;
        sb = r.ib;
        case (r.op)
            OP_MUL:  return r.ia * r.ib;
            OP_DIVU: return (r.ib == 0) ? '1 : r.ia / r.ib;
            OP_REMU: return (r.ib == 0) ? r.ia : r.ia % r.ib;
            OP_DIV: begin
                if (r.ib == 0) return '1;
                if (r.ia == 64'h8000_0000_0000_0000 && r.ib == '1) return r.ia;
                return u64'(sa / sb);
            end
            OP_REM: begin
                if (r.ib == 0) return r.ia;
                if (r.ia == 64'h8000_0000_0000_0000 && r.ib == '1) return '0;
                return u64'(sa % sb);
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_dz(input mbus_req_t r);
        return (r.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (r.ib == 0);
    endfunction

    // Behavioural core: result appears when busy drops; garbage while iterating.
    always @(posedge clk) begin
        if (core_rst) begin
            cnt <= 0;
        end else if (core_op_begin) begin
            res_q <= ref_data(core_req);
            dz_q  <= ref_dz(core_req);
            cnt   <= ref_dz(core_req) ? 0 : core_lat;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
        if (core_op_begin) nbegin <= nbegin + 1;
    end

    assign core_busy    = (cnt != 0);
    assign core_out     = core_busy ? 64'hDEAD_BEEF_DEAD_BEEF : res_q;
    assign core_divzero = core_busy ? 1'b0 : dz_q;

    function automatic bit fast_expected(input mbus_req_t r);
`ifdef MULDIV_FASTPATH_EN
        if (r.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU})
            return r.dw ? (r.ia == 0 || r.ib == 0) : (r.ia[31:0] == 0 || r.ib[31:0] == 0);
        return 1'b0;
`else
        return (r.op == OP_MUL) && 1'b0;
`endif
    endfunction

    function automatic int rr_winner(input logic [NREQ-1:0] v);
        int j;
        for (int k = 1; k <= NREQ; k++) begin
            j = (ptr_m + k) % NREQ;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    function automatic mbus_req_t mk(input op_e op, input logic dw, input u64 a, input u64 b);
        mbus_req_t r;
        r         = '0;
        r.op      = op;
        r.dw      = dw;
        r.ia      = a;
        r.ib      = b;
        r.ia_orig = a;
        return r;
    endfunction

    function automatic u64 rnd_operand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return u64'($urandom_range(1, 50));
            2:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [NREQ-1:0] vmask);
        @(negedge clk);
        req_valid = vmask;
        #1;
    endtask

    task automatic finish_op(input int lat_core, input int hold, input bit leave);
        mbus_req_t   r;
        int          w, lat, nb0, eff;
        bit          fast;
        logic [63:0] ed;
        logic        ez;
        core_lat = lat_core;
        for (int i = 0; i < 30 && req_ready == '0; i++) begin
            @(negedge clk);
            #1;
        end
        w = rr_winner(req_valid);
        check("grant", 64'(req_ready), 64'(onehot(w)));
        ptr_m = w;
        r     = req[w];
        fast  = fast_expected(r);
        ed    = fast ? 64'd0 : ref_data(r);
        ez    = fast ? 1'b0 : ref_dz(r);
        eff   = ez ? 0 : lat_core;
        nb0   = nbegin;
        @(negedge clk);
        req_valid = '0;
        #1;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("latency", 64'(lat), 64'(fast ? 1 : 3 + eff));
        check("op_begin_count", 64'(nbegin - nb0), 64'(fast ? 0 : 1));
        check("resp_id", 64'(resp_id), 64'(w));
        check("resp_data", resp_data, ed);
        check("resp_divzero", 64'(resp_divzero), 64'(ez));
        check("core_req_ib", core_req.ib, r.ib);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_data", resp_data, ed);
        end
        if (!leave) begin
            resp_ready = 1'b1;
            @(negedge clk);
            #1;
            check("resp_done", 64'(resp_valid), 64'd0);
            resp_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        seen;
        op_e       ops [5];
        logic [NREQ-1:0] vm;
        ops = '{OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        req[0]     = '0;
        req[1]     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_op_begin", 64'(core_op_begin), 64'd0);
        check("rst_core_req", core_req.ia, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_core_rst", 64'(core_rst), 64'd0);

        // Basic MUL, divide-by-zero DIV and REM
        req[0] = mk(OP_MUL, 1'b1, 64'd6, 64'd7);
        start(2'b01);
        finish_op(2, 0, 1'b0);
        req[1] = mk(OP_DIV, 1'b1, 64'd100, 64'd0);
        start(2'b10);
        finish_op(4, 0, 1'b0);
        req[1] = mk(OP_REM, 1'b1, 64'd100, 64'd0);
        start(2'b10);
        finish_op(4, 1, 1'b0);

        // Both requesters contend for four ops
        req[0] = mk(OP_MUL, 1'b1, 64'd3, 64'd5);
        req[1] = mk(OP_MUL, 1'b1, 64'd3, 64'd5);
        for (int i = 0; i < 4; i++) begin
            start(2'b11);
            finish_op(1, 0, 1'b0);
        end

        // Back-pressure: result held, no grant while RESP, grant right after release
        req[0] = mk(OP_MUL, 1'b1, 64'd2, 64'd21);
        start(2'b01);
        finish_op(0, 0, 1'b1);
        @(negedge clk);
        req[0]    = mk(OP_MUL, 1'b1, 64'd4, 64'd4);
        req[1]    = mk(OP_MUL, 1'b1, 64'd5, 64'd5);
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_data", resp_data, 64'd42);
            check("bp_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp_release", 64'(resp_valid), 64'd0);
        check("bp_regrant", 64'(req_ready), 64'(onehot(rr_winner(2'b11))));
        finish_op(0, 0, 1'b0);

        // Flush in IDLE is ignored
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("idle_flush_core_rst", 64'(core_rst), 64'd0);

        // Flush three cycles into WAIT drops the op
        req[0] = mk(OP_DIV, 1'b1, 64'd1000, 64'd7);
        core_lat = 10;
        start(2'b01);
        check("flush_grant", 64'(req_ready), 64'(onehot(rr_winner(req_valid))));
        ptr_m = 0;
        @(negedge clk);
        req_valid = '0;
        #1;
        check("flush_launch", 64'(core_op_begin), 64'd1);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_core_rst_on", 64'(core_rst), 64'd1);
        check("flush_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        #1;
        check("flush_core_rst_off", 64'(core_rst), 64'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("flush_no_resp", 64'(seen), 64'd0);
        req[0] = mk(OP_DIV, 1'b1, 64'd1000, 64'd7);
        start(2'b01);
        finish_op(3, 0, 1'b0);
        req[0] = mk(OP_REM, 1'b1, 64'd1000, 64'd7);
        start(2'b01);
        finish_op(3, 0, 1'b0);

        // Flush beats resp_ready in the same cycle
        req[1] = mk(OP_MUL, 1'b1, 64'd6, 64'd7);
        start(2'b10);
        finish_op(1, 0, 1'b1);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        resp_ready = 1'b0;
        #1;
        check("flush_prio_core_rst", 64'(core_rst), 64'd1);
        check("flush_prio_valid", 64'(resp_valid), 64'd0);

        // Zero-operand MUL (bypass when the fast path is built in)
        req[0] = mk(OP_MUL, 1'b1, 64'd0, 64'd9);
        start(2'b01);
        finish_op(2, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NREQ; i++)
                req[i] = mk(ops[$urandom_range(0, 4)], 1'b1, rnd_operand(), rnd_operand());
            vm = NREQ'($urandom_range(1, 3));
            start(vm);
            finish_op(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
